// File: rtl/ly_hit_stretch.sv
// ly_hit_stretch: per-wire programmable hit stretcher with registered
// layer occupancy count and any-hit flag.
module ly_hit_stretch #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 3,
    parameter int POP_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lyr,
    input  logic [1:0]       drift_delay,
    input  logic             trig_stop,
    output logic [WIDTH-1:0] lys,
    output logic             ly_active,
    output logic [POP_W-1:0] hit_cnt
);
    logic [CNT_W-1:0] load_len;
    logic [POP_W-1:0] pop_d;
    logic [POP_W-1:0] hit_cnt_q;
    logic             active_q;

    assign load_len = CNT_W'(drift_delay) + CNT_W'(1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_wire
        logic [CNT_W-1:0] cnt_q, cnt_d;
        // A retrigger reloads the full length rather than extending it.
        always_comb
            cnt_d = (lyr[i] && !trig_stop) ? load_len
                  : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        always_ff @(posedge clk)
            cnt_q <= !rst_n ? '0 : cnt_d;
        assign lys[i] = cnt_q != '0;
    end

    always_comb begin
        pop_d = '0;
        for (int k = 0; k < WIDTH; k++)
            pop_d = pop_d + POP_W'(lys[k]);
    end

    always_ff @(posedge clk) begin
        hit_cnt_q <= !rst_n ? '0 : pop_d;
        active_q  <= !rst_n ? 1'b0 : |lys;
    end

    assign hit_cnt   = hit_cnt_q;
    assign ly_active = active_q;
endmodule

// File: tb/tb_ly_hit_stretch.sv
// tb_ly_hit_stretch: scoreboard bench; a deadline-based model pushes the
// expected outputs for every edge, compared 1ns after that edge.
module tb_ly_hit_stretch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] lyr = '0;
    logic [1:0]  drift_delay = '0;
    logic        trig_stop = 1'b0;
    logic [63:0] lys;
    logic        ly_active;
    logic [6:0]  hit_cnt;

    ly_hit_stretch dut (
        .clk(clk), .rst_n(rst_n), .lyr(lyr), .drift_delay(drift_delay),
        .trig_stop(trig_stop), .lys(lys), .ly_active(ly_active), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] lys;
        logic        act;
        logic [6:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          edge_n = 0;
    int          end_t[64];
    logic [63:0] prev_lys = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: a wire stays high while the edge index is below its deadline.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            foreach (end_t[i]) end_t[i] = 0;
            e = '0;
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (lyr[i] && !trig_stop) end_t[i] = edge_n + int'(drift_delay) + 1;
                e.lys[i] = end_t[i] > edge_n;
            end
            e.act = |prev_lys;
            e.cnt = 7'($countones(prev_lys));
        end
        prev_lys = e.lys;
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("lys", lys, e.lys);
            chk("ly_active", 64'(ly_active), 64'(e.act));
            chk("hit_cnt", 64'(hit_cnt), 64'(e.cnt));
        end
    endtask

    task automatic pulse(input logic [63:0] v);
        lyr = v;
        tick();
        lyr = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        foreach (end_t[i]) end_t[i] = 0;
        #2;
        idle(2);
        chk("rst_lys", lys, 64'd0);
        rst_n = 1'b1;
        idle(2);

        drift_delay = 2'd2;
        pulse(64'd1 << 5);
        chk("single_lys5", 64'(lys[5]), 64'd1);
        idle(4);

        drift_delay = 2'd3;
        pulse(64'd1);
        tick();
        pulse(64'd1);
        idle(3);
        chk("retrig_still_high", 64'(lys[0]), 64'd1);
        tick();
        chk("retrig_dropped", 64'(lys[0]), 64'd0);
        pulse(64'd1);
        idle(5);

        drift_delay = 2'd1;
        pulse(64'd1 << 10);
        trig_stop = 1'b1;
        pulse((64'd1 << 10) | (64'd1 << 20));
        chk("stop_lys20", 64'(lys[20]), 64'd0);
        idle(3);
        trig_stop = 1'b0;

        drift_delay = 2'd0;
        pulse('1);
        chk("full_lys", lys, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("full_cnt", 64'(hit_cnt), 64'd64);
        tick();
        chk("full_cnt_after", 64'(hit_cnt), 64'd0);

        drift_delay = 2'd3;
        pulse(64'd1 << 63);
        rst_n = 1'b0;
        tick();
        chk("midrst_lys", lys, 64'd0);
        rst_n = 1'b1;
        idle(3);
        chk("midrst_cnt", 64'(hit_cnt), 64'd0);

        for (int k = 0; k < 400; k++) begin
            drift_delay = 2'($urandom_range(0, 3));
            trig_stop = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 63) != 0);
            lyr = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 31) == 0) lyr = '1;
            tick();
        end
        rst_n = 1'b1;
        trig_stop = 1'b0;
        lyr = '0;
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
